// File: rtl/addr_sequencer.sv
// Digit-index sequencer: free-running prescaled count or single-step, up/down with wrap.
// Optional step debounce enabled by defining SEQ_DEBOUNCE_EN.
module addr_sequencer #(
    parameter int TICK_DIV   = 25000000,
    parameter int DIV_W      = 25,
    parameter int LAST       = 15,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       dir,
    input  logic       step_btn,
    output logic [3:0] addr,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       LAST_V   = 4'(LAST);

    // Reject configurations the arithmetic below cannot honour
    if (TICK_DIV < 2 || LAST < 0 || LAST > 15 || DEB_CYCLES < 1 ||
        (DIV_W < 31 && (64'(1) << DIV_W) < 64'(TICK_DIV))) begin : g_bad_param
        $error("addr_sequencer: illegal parameter combination");
    end

    state_t           state_reg;
    state_t           state_next;
    logic             run_m, run_s;
    logic             dir_m, dir_s;
    logic             step_m, step_s;
    logic             step_lvl;
    logic             step_d;
    logic             step_edge;
    logic [DIV_W-1:0] div_reg;
    logic             terminal;
    logic             advance;
    logic [3:0]       addr_reg, addr_next;
    logic             tick_reg;
    logic             wrap_reg, wrap_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_m  <= 1'b0;
            run_s  <= 1'b0;
            dir_m  <= 1'b0;
            dir_s  <= 1'b0;
            step_m <= 1'b0;
            step_s <= 1'b0;
        end else begin
            run_m  <= run;
            run_s  <= run_m;
            dir_m  <= dir;
            dir_s  <= dir_m;
            step_m <= step_btn;
            step_s <= step_m;
        end
    end

`ifdef SEQ_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt_reg;
    logic             deb_lvl_reg;

    // Filtered level flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt_reg <= '0;
            deb_lvl_reg <= 1'b0;
        end else if (step_s != deb_lvl_reg) begin
            if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                deb_lvl_reg <= step_s;
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end else begin
            deb_cnt_reg <= '0;
        end
    end

    assign step_lvl = deb_lvl_reg;
`else
    assign step_lvl = step_s;
`endif

    assign step_edge = step_lvl & ~step_d;
    assign terminal  = (div_reg == DIV_TERM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= PAUSE;
            step_d    <= 1'b0;
            div_reg   <= '0;
        end else begin
            state_reg <= state_next;
            step_d    <= step_lvl;
            if (state_reg == RUN) begin
                div_reg <= terminal ? '0 : div_reg + 1'b1;
            end else begin
                div_reg <= '0;
            end
        end
    end

    // Advance source is chosen by the current state, so a step during the
    // RUN->PAUSE transition cycle is dropped.
    always_comb begin
        state_next = state_reg;
        advance    = 1'b0;
        case (state_reg)
            PAUSE: begin
                advance = step_edge;
                if (run_s) state_next = RUN;
            end
            RUN: begin
                advance = terminal;
                if (!run_s) state_next = PAUSE;
            end
            default: state_next = PAUSE;
        endcase
    end

    always_comb begin
        addr_next = addr_reg;
        wrap_next = 1'b0;
        if (dir_s) begin
            wrap_next = (addr_reg == 4'd0);
            addr_next = wrap_next ? LAST_V : addr_reg - 1'b1;
        end else begin
            wrap_next = (addr_reg == LAST_V);
            addr_next = wrap_next ? 4'd0 : addr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg <= 4'd0;
            tick_reg <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            tick_reg <= advance;
            wrap_reg <= advance & wrap_next;
            if (advance) addr_reg <= addr_next;
        end
    end

    assign addr = addr_reg;
    assign tick = tick_reg;
    assign wrap = wrap_reg;

endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Generates the 4-bit digit index that drives the combinational digit-lookup converter. That converter maps each index to a hex digit for the display path.
- Two modes:
  - Free-running: advances at a prescaled rate.
  - Paused: advances one index per press of a single-step pushbutton.
- Sits between the board inputs (switches and button) and the converter's `in` port.

Parameters:
- TICK_DIV, 25000000: clock cycles between automatic advances in run mode. Must be ≥ 2.
- DIV_W, 25: prescaler counter width. Must satisfy 2^DIV_W ≥ TICK_DIV.
- LAST, 15: highest index value. The index range is 0..LAST, with LAST ≤ 15.
- DEB_CYCLES, 1000000: debounce stability window in cycles. Used only when the optional feature is enabled.

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- rst_n  input  1  synchronous, active-low reset
- run  input  1  asynchronous switch; 1 = run mode, 0 = paused
- dir  input  1  asynchronous switch; 0 = count up, 1 = count down
- step_btn  input  1  asynchronous raw pushbutton, active high
- addr  output  4  current index; feeds the converter `in` port
- tick  output  1  one-cycle pulse, registered, high in the same cycle that addr takes its new value
- wrap  output  1  one-cycle pulse, coincident with tick, when the index wraps (LAST→0 or 0→LAST)

Behaviour:
- Reset: only on a clk edge with rst_n=0. Reset values:
  - addr=0, tick=0, wrap=0
  - prescaler=0
  - all synchroniser and edge flops=0
  - state=PAUSE
- Reset has priority over every other event. Asserting reset mid-run discards prescaler progress and any pending step.
- Synchronisers: run, dir and step_btn each pass through a 2-FF synchroniser, giving run_s, dir_s and step_s.
- Step edge:
  - step_d is step_s delayed by one register.
  - step_edge = step_s & ~step_d.
  - A raw press first sampled at edge k produces an addr update at edge k+2.
- State machine (2 states):
  - PAUSE → RUN when run_s=1.
  - RUN → PAUSE when run_s=0.
  - The state register updates on the edge after run_s changes.
- Prescaler:
  - In RUN: counts 0..TICK_DIV-1. The advance fires on the cycle the count equals TICK_DIV-1, and the count then returns to 0.
  - In PAUSE: held at 0.
  - On entry to RUN, the first advance occurs exactly TICK_DIV cycles after entry.
- Advance rules:
  - In RUN: an advance happens only on prescaler terminal. step_edge is ignored.
  - In PAUSE: an advance happens only on step_edge.
  - At most one advance per cycle.
- Advance arithmetic:
  - dir_s=0: addr = (addr==LAST) ? 0 : addr+1, with wrap=1 on the LAST→0 transition.
  - dir_s=1: addr = (addr==0) ? LAST : addr-1, with wrap=1 on the 0→LAST transition.
- dir_s is sampled at the advance cycle, so a direction change mid-run takes effect at the next advance.
- tick and wrap are high for exactly one cycle per advance and low otherwise.
- A step held high for any duration produces exactly one advance. Bounce produces multiple advances unless the optional feature is enabled.
- A mode switch in the same cycle as a pending step_edge:
  - The edge is evaluated against the current state register, not the next one.
  - Pressing step during the RUN→PAUSE transition cycle is therefore ignored.

Optional Feature:
- Macro: SEQ_DEBOUNCE_EN.
- Defined:
  - step_s feeds a debounce counter. The filtered level changes only after step_s has differed from it for DEB_CYCLES consecutive cycles.
  - step_edge is derived from the filtered level.
  - Press latency becomes k+2+DEB_CYCLES edges.
  - The counter resets to 0 under rst_n.
- Undefined:
  - No debounce logic or counter is instantiated.
  - step_edge comes directly from step_s as above.
  - DEB_CYCLES is unused.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with run=1 and step_btn=1 → addr=0, tick=0, wrap=0. Once rst_n=1 with run=1, the first advance (addr=1) occurs TICK_DIV cycles after the state reaches RUN. The stepping behaviour is checked in scenario 3.
2. Run up: TICK_DIV=4, run=1, dir=0 → addr steps 0,1,…,15,0 with one step every 4 cycles. tick pulses on every step; wrap pulses only on 15→0.
3. Single step: run=0, addr=5. Press step_btn for 3 cycles → addr=6 two edges after the first sample, tick=1 for one cycle. Holding for 50 cycles still gives addr=6. With SEQ_DEBOUNCE_EN and DEB_CYCLES=8, a 1-0-1 glitch pattern shorter than 8 cycles gives no advance.
4. Down wrap: run=0, dir=1, addr=0, one step → addr=15, wrap=1. Another step → addr=14, wrap=0.
5. Mid-run reset: TICK_DIV=4, run=1, reset asserted at addr=9 with the prescaler at 2 → addr=0 on the next edge, prescaler=0, no tick pulse.
6. Step in run ignored: run=1, pulse step_btn between ticks → addr changes only on the prescaler schedule. Toggling dir mid-run: the next advance follows the new direction.
